uart_tx_slave: RTL and testbench

//  Bus slave that turns byte writes into an 8N1 serial stream on txd.

---
 rtl/uart_tx_slave.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_slave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_slave.sv
// uart_tx_slave: bus slave that queues byte writes in a FIFO and sends them as 8N1 frames on txd.
// Registers on addr[3:2]: 0 TXDATA (W), 1 STATUS (RO), 2 BAUDDIV (RW), 3 reserved.
module uart_tx_slave #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter int unsigned DIV_RESET  = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   output logic        ready,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        tx_empty
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state;
   logic [7:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]        wptr, rptr;
   logic [AW:0]          count;
   logic [DIV_WIDTH-1:0] bauddiv, baud_cnt, period_m1, div_new;
   logic [7:0]           shreg;
   logic [2:0]           bitcnt;
   logic [31:0]          rd_val, wmask;
   logic                 full, empty, is_tx_wr, accept, push, pop, bit_end;
   logic                 unused_bits;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign bit_end  = (baud_cnt == '0);
   assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_end));
   assign is_tx_wr = (addr[3:2] == 2'd0) && wstrb[0];
   // A TXDATA write into a full FIFO is only taken on an edge that also pops.
   assign accept   = valid && !ready && !(is_tx_wr && full && !pop);
   assign push     = accept && is_tx_wr;
   assign tx_empty = empty && (state == IDLE);

   assign wmask       = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   assign unused_bits = ^{addr[31:4], addr[1:0], wdata, wmask};

   always_comb begin
      rd_val = '0;
      case (addr[3:2])
         2'd1: begin
            rd_val[0]          = (state != IDLE);
            rd_val[1]          = full;
            rd_val[2]          = empty;
            rd_val[8 +: AW+1]  = count;
         end
         2'd2:    rd_val[DIV_WIDTH-1:0] = bauddiv;
         default: ;
      endcase
   end

   always_comb begin
      div_new   = (bauddiv & ~wmask[DIV_WIDTH-1:0]) | (wdata[DIV_WIDTH-1:0] & wmask[DIV_WIDTH-1:0]);
      period_m1 = bauddiv - 1'b1;
      if (bauddiv[DIV_WIDTH-1:1] == '0)
         period_m1 = DIV_WIDTH'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready   <= 1'b0;
         rdata   <= '0;
         bauddiv <= DIV_WIDTH'(DIV_RESET);
      end else begin
         ready <= accept;
         rdata <= accept ? rd_val : '0;
         if (accept && addr[3:2] == 2'd2)
            bauddiv <= div_new;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= wdata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         shreg    <= '0;
         bitcnt   <= '0;
         txd      <= 1'b1;
      end else begin
         // txd trails the state by one cycle, so every bit keeps its full period.
         case (state)
            START:   txd <= 1'b0;
            DATA:    txd <= shreg[0];
            default: txd <= 1'b1;
         endcase
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg    <= mem[rptr];
                  baud_cnt <= period_m1;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= period_m1;
                  bitcnt   <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= period_m1;
                  shreg    <= {1'b0, shreg[7:1]};
                  bitcnt   <= bitcnt + 1'b1;
                  if (bitcnt == 3'd7)
                     state <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shreg    <= mem[rptr];
                     baud_cnt <= period_m1;
                     state    <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Testbench for uart_tx_slave: directed and randomized bus traffic, txd checked against
// frames rebuilt from the written bytes and the bit period rule P = max(BAUDDIV, 2).
module tb_uart_tx_slave;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        txd;
   logic        tx_empty;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic        hist[$];
   logic [7:0]  exp_q[$];
   logic [31:0] div_m;
   int unsigned scan;

   uart_tx_slave #(.FIFO_DEPTH(16), .DIV_WIDTH(16), .DIV_RESET(868)) dut (
      .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .txd(txd), .tx_empty(tx_empty)
   );

   always #5 clk = ~clk;

   // one txd sample per cycle, taken away from the active edge
   always @(negedge clk) hist.push_back(txd);

   initial begin
      #900000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int unsigned lat, output int unsigned rcyc);
      @(negedge clk);
      addr = a; wdata = d; wstrb = s; valid = 1'b1; lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!ready && lat < 3000);
      chk("bus_ack", 32'(ready), 32'd1);
      rd   = rdata;
      rcyc = $unsigned(hist.size());
      valid = 1'b0; wstrb = '0;
      @(posedge clk); #1;
   endtask

   task automatic rd_reg(input logic [31:0] a, output logic [31:0] rd);
      int unsigned lat, rc;
      bus(a, $urandom, 4'b0000, rd, lat, rc);
   endtask

   task automatic wr_div(input logic [31:0] d, input logic [3:0] s, output int unsigned lat);
      logic [31:0] m, rd;
      int unsigned rc;
      m     = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      div_m = ((div_m & ~m) | (d & m)) & 32'h0000_FFFF;
      bus(32'h8, d, s, rd, lat, rc);
   endtask

   task automatic wr_tx(input logic [7:0] b, output int unsigned lat, output int unsigned rc);
      logic [31:0] rd;
      exp_q.push_back(b);
      bus(32'h0, {24'($urandom), b}, 4'b0001, rd, lat, rc);
   endtask

   function automatic int unsigned period();
      return (div_m < 2) ? 2 : div_m;
   endfunction

   task automatic wait_hist(input int unsigned i, output logic ok);
      int unsigned w = 0;
      while ($unsigned(hist.size()) <= i && w < 20000) begin
         @(posedge clk); w++;
      end
      ok = ($unsigned(hist.size()) > i);
   endtask

   // Locates the next start bit at or after scan and compares every cycle of the frame.
   task automatic expect_frame(input string tag, input int unsigned p0, input int unsigned p,
                               output int unsigned st);
      logic [7:0]  b;
      logic [9:0]  fr, sh;
      int unsigned i, bad, len, lim;
      logic        ok;
      b   = exp_q.pop_front();
      fr  = {1'b1, b, 1'b0};
      i   = scan; bad = 0; lim = scan + 1000;
      wait_hist(i, ok);
      while (ok && hist[i] !== 1'b0 && i < lim) begin
         i++;
         wait_hist(i, ok);
      end
      st = i;
      for (int k = 0; k < 10; k++) begin
         sh  = fr >> k;
         len = (k == 0) ? p0 : p;
         for (int unsigned c = 0; c < len; c++) begin
            wait_hist(i, ok);
            if (!ok || hist[i] !== sh[0]) bad++;
            i++;
         end
      end
      scan = i;
      chk(tag, bad, 32'd0);
   endtask

   initial begin
      logic [31:0] rd, d;
      logic [3:0]  s;
      int unsigned lat, rc, st0, st1, prev, zeros, n, p;

      reset = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
      div_m = 32'd868; scan = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_tx_empty", 32'(tx_empty), 32'd1);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(negedge clk); reset = 1'b0;

      // register map
      rd_reg(32'h4, rd); chk("status_reset", rd, 32'h0000_0004);
      rd_reg(32'h8, rd); chk("bauddiv_reset", rd, 32'd868);
      chk("rdata_idle", rdata, 32'd0);
      wr_div(32'hABCD_0000, 4'b0011, lat);
      rd_reg(32'h8, rd); chk("bauddiv_clear", rd, div_m);
      wr_div(32'h0000_0010, 4'b0001, lat);
      chk("bauddiv_wr_latency", lat, 32'd1);
      rd_reg(32'h8, rd); chk("bauddiv_0x10", rd, 32'h10);
      d = $urandom; s = 4'($urandom_range(1, 15));
      wr_div(d, s, lat);
      rd_reg(32'h8, rd); chk("bauddiv_strobes", rd, div_m);
      rd_reg(32'hC, rd); chk("reserved_read", rd, 32'd0);
      bus(32'hC, 32'hFFFF_FFFF, 4'hF, rd, lat, rc); chk("reserved_wr_latency", lat, 32'd1);
      rd_reg(32'h0, rd); chk("txdata_read", rd, 32'd0);
      chk("txdata_read_no_push", 32'(tx_empty), 32'd1);

      // single frame 0x41 at P=4
      wr_div(32'd4, 4'hF, lat);
      scan = $unsigned(hist.size());
      wr_tx(8'h41, lat, rc);
      chk("t1_latency", lat, 32'd1);
      expect_frame("t1_frame", 4, 4, st0);
      chk("t1_start_delay", st0, rc + 2);
      @(posedge clk); #1;
      chk("t1_tx_empty", 32'(tx_empty), 32'd1);

      // BAUDDIV 0 and 1 clamp to P=2, then a mid-bit divider change
      wr_div(32'd0, 4'hF, lat);
      scan = $unsigned(hist.size());
      wr_tx(8'($urandom), lat, rc);
      expect_frame("t6_div0", 2, 2, st0);
      wr_div(32'd1, 4'hF, lat);
      scan = $unsigned(hist.size());
      wr_tx(8'($urandom), lat, rc);
      expect_frame("t6_div1", 2, 2, st0);
      wr_div(32'd4, 4'hF, lat);
      scan = $unsigned(hist.size());
      wr_tx(8'($urandom), lat, rc);
      wr_div(32'd8, 4'hF, lat);
      expect_frame("t6_midbit", 4, 8, st0);

      // "Hi" back to back at P=4
      wr_div(32'd4, 4'hF, lat);
      scan = $unsigned(hist.size());
      wr_tx(8'h48, lat, rc); chk("t2_latency_h", lat, 32'd1);
      wr_tx(8'h69, lat, rc); chk("t2_latency_i", lat, 32'd1);
      expect_frame("t2_frame_h", 4, 4, st0);
      expect_frame("t2_frame_i", 4, 4, st1);
      chk("t2_gap", st1 - st0, 32'd40);

      // randomized bursts
      for (int r = 0; r < 3; r++) begin
         wr_div($urandom_range(0, 6), 4'hF, lat);
         p = period();
         n = $urandom_range(2, 4);
         scan = $unsigned(hist.size());
         for (int unsigned j = 0; j < n; j++) wr_tx(8'($urandom), lat, rc);
         for (int unsigned j = 0; j < n; j++) begin
            expect_frame("rand_frame", p, p, st1);
            if (j > 0) chk("rand_gap", st1 - prev, 10 * p);
            prev = st1;
         end
      end

      // FIFO full stall: one byte goes straight to the serialiser, 16 fill the FIFO
      wr_div(32'd20, 4'hF, lat);
      scan = $unsigned(hist.size());
      for (int j = 0; j < 17; j++) begin
         wr_tx(8'($urandom), lat, rc);
         chk("t3_fill_latency", lat, 32'd1);
      end
      rd_reg(32'h4, rd); chk("t3_status_full", rd, 32'h0000_1003);
      wr_tx(8'($urandom), lat, rc);
      chk("t3_stalled", 32'(lat > 1), 32'd1);
      expect_frame("t3_frame", 20, 20, st0);
      expect_frame("t3_frame", 20, 20, st1);
      chk("t3_gap", st1 - st0, 32'd200);
      chk("t3_ready_at_pop", st1, rc + 1);
      prev = st1;
      for (int j = 0; j < 16; j++) begin
         expect_frame("t3_frame", 20, 20, st1);
         chk("t3_gap", st1 - prev, 32'd200);
         prev = st1;
      end
      @(posedge clk); #1;
      chk("t3_drained", 32'(tx_empty), 32'd1);
      rd_reg(32'h4, rd); chk("t3_status_drained", rd, 32'h0000_0004);

      // reset in the middle of a data bit
      wr_div(32'd4, 4'hF, lat);
      wr_tx(8'($urandom), lat, rc);
      repeat (8) @(posedge clk);
      #3; reset = 1'b1;
      #1;
      chk("t5_txd", 32'(txd), 32'd1);
      chk("t5_tx_empty", 32'(tx_empty), 32'd1);
      chk("t5_ready", 32'(ready), 32'd0);
      exp_q.delete();
      div_m = 32'd868;
      @(posedge clk); #1; reset = 1'b0;
      scan = $unsigned(hist.size());
      rd_reg(32'h4, rd); chk("t5_status", rd, 32'h0000_0004);
      rd_reg(32'h8, rd); chk("t5_bauddiv", rd, div_m);
      repeat (60) @(posedge clk);
      zeros = 0;
      for (int unsigned i = scan; i < $unsigned(hist.size()); i++)
         if (hist[i] !== 1'b1) zeros++;
      chk("t5_no_residual", zeros, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
